// File: rtl/alu_seq_if.sv
// Handshake bundle between the control unit / ALU datapath and the alu_seq sequencer.
interface alu_seq_if;
  logic       start;
  logic [2:0] cmd;
  logic       flg_rd;
  logic       clr;
  logic       opnd_vld;
  logic       bus_gnt;
  logic       busy;
  logic       done;
  logic       err;
  logic       ld_a;
  logic       ld_b;
  logic [2:0] alu_fn;
  logic [1:0] op_sel;
  logic       lrst;
  logic       bus_req;
  logic       ws1;
  logic       ws2;

  modport master (
    output start, cmd, flg_rd, clr, opnd_vld, bus_gnt,
    input  busy, done, err, ld_a, ld_b, alu_fn, op_sel, lrst, bus_req, ws1, ws2
  );

  modport slave (
    input  start, cmd, flg_rd, clr, opnd_vld, bus_gnt,
    output busy, done, err, ld_a, ld_b, alu_fn, op_sel, lrst, bus_req, ws1, ws2
  );
endinterface

// File: rtl/alu_seq.sv
// Sequencer for the 4-bit ALU: operand load, execute, bus acquisition and
// result/flag write-back, with a per-wait-state timeout abort.
module alu_seq #(
  parameter int unsigned TMO = 8,
  parameter int unsigned CW  = 8
) (
  input  logic     clk,
  input  logic     grst,
  alu_seq_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_LDA, S_LDB, S_EXEC, S_REQ, S_WRES, S_WFLG, S_DONE, S_ABORT
  } state_t;

  localparam logic [CW-1:0] TMO_LAST = CW'(TMO - 1);

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_fn;
  logic          r_flg;

  logic       w_wait, w_in, w_expire, w_accept;
  logic       w_busy, w_done, w_err, w_ld_a, w_ld_b, w_lrst, w_req, w_ws1, w_ws2;
  logic [1:0] w_op_sel;

  // Wait states and the input each one is waiting on
  always_comb begin
    w_wait = 1'b0;
    w_in   = 1'b0;
    case (r_state)
      S_LDA, S_LDB:          begin w_wait = 1'b1; w_in = bus.opnd_vld; end
      S_REQ, S_WRES, S_WFLG: begin w_wait = 1'b1; w_in = bus.bus_gnt;  end
      default: ;
    endcase
  end

  assign w_expire = w_wait & ~w_in & (r_cnt == TMO_LAST);
  assign w_accept = (r_state == S_IDLE) & ~bus.clr & bus.start;

  always_comb begin
    w_next   = r_state;
    w_busy   = 1'b1;
    w_done   = 1'b0;
    w_err    = 1'b0;
    w_ld_a   = 1'b0;
    w_ld_b   = 1'b0;
    w_lrst   = 1'b0;
    w_req    = 1'b0;
    w_ws1    = 1'b0;
    w_ws2    = 1'b0;
    w_op_sel = 2'b00;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.clr)        w_next = S_CLR;
        else if (bus.start) w_next = S_LDA;
      end
      S_CLR: begin
        w_lrst = 1'b1;
        w_next = S_DONE;
      end
      S_LDA: begin
        w_ld_a = bus.opnd_vld;
        if (bus.opnd_vld) w_next = r_fn[2] ? S_EXEC : S_LDB;
        else if (w_expire) w_next = S_ABORT;
      end
      S_LDB: begin
        w_ld_b = bus.opnd_vld;
        if (bus.opnd_vld)  w_next = S_EXEC;
        else if (w_expire) w_next = S_ABORT;
      end
      S_EXEC: begin
        w_op_sel = r_fn[2] ? 2'b10 : 2'b01;
        w_next   = S_REQ;
      end
      S_REQ: begin
        w_req = 1'b1;
        if (bus.bus_gnt)   w_next = S_WRES;
        else if (w_expire) w_next = S_ABORT;
      end
      S_WRES: begin
        w_req = 1'b1;
        w_ws1 = bus.bus_gnt;
        if (bus.bus_gnt)   w_next = r_flg ? S_WFLG : S_DONE;
        else if (w_expire) w_next = S_ABORT;
      end
      S_WFLG: begin
        w_req = 1'b1;
        w_ws2 = bus.bus_gnt;
        if (bus.bus_gnt)   w_next = S_DONE;
        else if (w_expire) w_next = S_ABORT;
      end
      S_DONE: begin
        w_busy = 1'b0;
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      S_ABORT: begin
        w_err  = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge grst) begin
    if (grst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_fn    <= '0;
      r_flg   <= 1'b0;
    end else begin
      r_state <= w_next;
      // Timeout count restarts on every state change, so an expiry also clears it
      if (w_next != r_state)       r_cnt <= '0;
      else if (w_wait && !w_in)    r_cnt <= r_cnt + CW'(1);
      if (w_accept) begin
        r_fn  <= bus.cmd;
        r_flg <= bus.flg_rd;
      end
    end
  end

  assign bus.busy    = w_busy;
  assign bus.done    = w_done;
  assign bus.err     = w_err;
  assign bus.ld_a    = w_ld_a;
  assign bus.ld_b    = w_ld_b;
  assign bus.alu_fn  = r_fn;
  assign bus.op_sel  = w_op_sel;
  assign bus.lrst    = w_lrst;
  assign bus.bus_req = w_req;
  assign bus.ws1     = w_ws1;
  assign bus.ws2     = w_ws2;

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq: per-cycle output snapshots compared
// against hand-derived expected vectors.
module tb_alu_seq;
  logic clk = 1'b0;
  logic grst;
  always #5 clk = ~clk;

  alu_seq_if bif();

  alu_seq #(.TMO(8), .CW(8)) dut (
    .clk  (clk),
    .grst (grst),
    .bus  (bif)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  logic [13:0] snap [0:15];

  // {busy,done,err,ld_a,ld_b,alu_fn,op_sel,lrst,bus_req,ws1,ws2}
  function automatic logic [13:0] pack();
    return {bif.busy, bif.done, bif.err, bif.ld_a, bif.ld_b, bif.alu_fn,
            bif.op_sel, bif.lrst, bif.bus_req, bif.ws1, bif.ws2};
  endfunction

  function automatic logic [13:0] mk(input logic b, d, e, la, lb, input logic [2:0] fn,
                                     input logic [1:0] op, input logic lr, rq, w1, w2);
    return {b, d, e, la, lb, fn, op, lr, rq, w1, w2};
  endfunction

  task automatic check(input string tag, input logic [13:0] got, input logic [13:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Entered at posedge+1 of cycle 0; drives per-cycle patterns and snapshots at negedge.
  // Outside cycle 0, cmd/flg_rd are driven inverted so an accepted stray start would show.
  task automatic run(input logic [2:0] c, input logic f, input logic cl,
                     input logic [31:0] sp, input logic [31:0] vp, input logic [31:0] gp,
                     input int n);
    for (int k = 0; k < n; k++) begin
      bif.start    = sp[k];
      bif.cmd      = (k == 0) ? c : ~c;
      bif.flg_rd   = (k == 0) ? f : ~f;
      bif.clr      = (k == 0) ? cl : 1'b0;
      bif.opnd_vld = vp[k];
      bif.bus_gnt  = gp[k];
      @(negedge clk);
      snap[k] = pack();
      @(posedge clk);
      #1;
    end
    bif.start = 1'b0;
    bif.clr   = 1'b0;
  endtask

  task automatic expect_seq(input string tag, input int n, input logic [13:0] exp [0:15]);
    for (int k = 0; k < n; k++)
      check($sformatf("%s_c%0d", tag, k), snap[k], exp[k]);
  endtask

  logic [13:0] ev [0:15];
  int unsigned cnt;

  initial begin
    grst = 1'b1;
    bif.start = 0; bif.cmd = 0; bif.flg_rd = 0; bif.clr = 0;
    bif.opnd_vld = 1; bif.bus_gnt = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", pack(), '0);
    #1 grst = 1'b0;
    @(posedge clk); #1;

    // grst in LDB: everything returns to zero, no done/err/ws afterwards
    bif.start = 1'b1; bif.cmd = 3'b011;
    @(posedge clk); #1 bif.start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_pre_ldb", pack(), mk(1,0,0,0,1,3'b011,2'b00,0,0,0,0));
    grst = 1'b1;
    #1 check("rst_async", pack(), '0);
    @(posedge clk); #1 grst = 1'b0;
    @(negedge clk);
    check("rst_after", pack(), '0);
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (bif.done || bif.err || bif.ws1 || bif.ws2 || bif.busy) cnt++;
    end
    check("rst_quiet", 14'(cnt), '0);
    @(posedge clk); #1;

    // Binary, no flags; stray starts in LDB and DONE
    ev[0] = mk(0,0,0,0,0,3'b000,2'b00,0,0,0,0);
    ev[1] = mk(1,0,0,1,0,3'b011,2'b00,0,0,0,0);
    ev[2] = mk(1,0,0,0,1,3'b011,2'b00,0,0,0,0);
    ev[3] = mk(1,0,0,0,0,3'b011,2'b01,0,0,0,0);
    ev[4] = mk(1,0,0,0,0,3'b011,2'b00,0,1,0,0);
    ev[5] = mk(1,0,0,0,0,3'b011,2'b00,0,1,1,0);
    ev[6] = mk(0,1,0,0,0,3'b011,2'b00,0,0,0,0);
    ev[7] = mk(0,0,0,0,0,3'b011,2'b00,0,0,0,0);
    run(3'b011, 1'b0, 1'b0, 32'h45, '1, '1, 8);
    expect_seq("bin", 8, ev);

    // Unary with flags
    ev[0] = mk(0,0,0,0,0,3'b011,2'b00,0,0,0,0);
    ev[1] = mk(1,0,0,1,0,3'b101,2'b00,0,0,0,0);
    ev[2] = mk(1,0,0,0,0,3'b101,2'b10,0,0,0,0);
    ev[3] = mk(1,0,0,0,0,3'b101,2'b00,0,1,0,0);
    ev[4] = mk(1,0,0,0,0,3'b101,2'b00,0,1,1,0);
    ev[5] = mk(1,0,0,0,0,3'b101,2'b00,0,1,0,1);
    ev[6] = mk(0,1,0,0,0,3'b101,2'b00,0,0,0,0);
    ev[7] = mk(0,0,0,0,0,3'b101,2'b00,0,0,0,0);
    run(3'b101, 1'b1, 1'b0, 32'h1, '1, '1, 8);
    expect_seq("unf", 8, ev);

    // Grant late in REQ, then lost for two cycles in WRES
    ev[0] = mk(0,0,0,0,0,3'b101,2'b00,0,0,0,0);
    ev[1] = mk(1,0,0,1,0,3'b000,2'b00,0,0,0,0);
    ev[2] = mk(1,0,0,0,1,3'b000,2'b00,0,0,0,0);
    ev[3] = mk(1,0,0,0,0,3'b000,2'b01,0,0,0,0);
    for (int k = 4; k <= 9; k++) ev[k] = mk(1,0,0,0,0,3'b000,2'b00,0,1,0,0);
    ev[10] = mk(1,0,0,0,0,3'b000,2'b00,0,1,1,0);
    ev[11] = mk(0,1,0,0,0,3'b000,2'b00,0,0,0,0);
    run(3'b000, 1'b0, 1'b0, 32'h1, '1, 32'hFFFF_FC80, 12);
    expect_seq("gnt", 12, ev);
    cnt = 0;
    for (int k = 0; k < 12; k++) cnt += snap[k][1];
    check("gnt_ws1_once", 14'(cnt), 14'd1);

    // Bus grant never arrives: abort after 8 REQ cycles
    ev[0] = mk(0,0,0,0,0,3'b000,2'b00,0,0,0,0);
    ev[1] = mk(1,0,0,1,0,3'b011,2'b00,0,0,0,0);
    ev[2] = mk(1,0,0,0,1,3'b011,2'b00,0,0,0,0);
    ev[3] = mk(1,0,0,0,0,3'b011,2'b01,0,0,0,0);
    for (int k = 4; k <= 11; k++) ev[k] = mk(1,0,0,0,0,3'b011,2'b00,0,1,0,0);
    ev[12] = mk(1,0,1,0,0,3'b011,2'b00,0,0,0,0);
    ev[13] = mk(0,0,0,0,0,3'b011,2'b00,0,0,0,0);
    run(3'b011, 1'b0, 1'b0, 32'h1, '1, '0, 14);
    expect_seq("tmo", 14, ev);

    // Next command after abort: unary, no flags, done one cycle earlier
    ev[0] = mk(0,0,0,0,0,3'b011,2'b00,0,0,0,0);
    ev[1] = mk(1,0,0,1,0,3'b110,2'b00,0,0,0,0);
    ev[2] = mk(1,0,0,0,0,3'b110,2'b10,0,0,0,0);
    ev[3] = mk(1,0,0,0,0,3'b110,2'b00,0,1,0,0);
    ev[4] = mk(1,0,0,0,0,3'b110,2'b00,0,1,1,0);
    ev[5] = mk(0,1,0,0,0,3'b110,2'b00,0,0,0,0);
    run(3'b110, 1'b0, 1'b0, 32'h1, '1, '1, 6);
    expect_seq("un", 6, ev);

    // Grant arriving on the expiry cycle wins
    ev[0] = mk(0,0,0,0,0,3'b110,2'b00,0,0,0,0);
    ev[1] = mk(1,0,0,1,0,3'b011,2'b00,0,0,0,0);
    ev[2] = mk(1,0,0,0,1,3'b011,2'b00,0,0,0,0);
    ev[3] = mk(1,0,0,0,0,3'b011,2'b01,0,0,0,0);
    for (int k = 4; k <= 11; k++) ev[k] = mk(1,0,0,0,0,3'b011,2'b00,0,1,0,0);
    ev[12] = mk(1,0,0,0,0,3'b011,2'b00,0,1,1,0);
    ev[13] = mk(0,1,0,0,0,3'b011,2'b00,0,0,0,0);
    run(3'b011, 1'b0, 1'b0, 32'h1, '1, 32'hFFFF_F800, 14);
    expect_seq("race", 14, ev);

    // Operand never valid: abort from LDA
    ev[0] = mk(0,0,0,0,0,3'b011,2'b00,0,0,0,0);
    for (int k = 1; k <= 8; k++) ev[k] = mk(1,0,0,0,0,3'b000,2'b00,0,0,0,0);
    ev[9]  = mk(1,0,1,0,0,3'b000,2'b00,0,0,0,0);
    ev[10] = mk(0,0,0,0,0,3'b000,2'b00,0,0,0,0);
    run(3'b000, 1'b0, 1'b0, 32'h1, '0, '1, 11);
    expect_seq("vtmo", 11, ev);

    // clr beats start; start during CLR ignored
    ev[0] = mk(0,0,0,0,0,3'b000,2'b00,0,0,0,0);
    ev[1] = mk(1,0,0,0,0,3'b000,2'b00,1,0,0,0);
    ev[2] = mk(0,1,0,0,0,3'b000,2'b00,0,0,0,0);
    ev[3] = mk(0,0,0,0,0,3'b000,2'b00,0,0,0,0);
    run(3'b111, 1'b0, 1'b1, 32'h3, '1, '1, 4);
    expect_seq("clr", 4, ev);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Sequencer for the 4-bit ALU unit. It loads operands from the shared 4-bit bus, fires the ALU/result register, and gains bus ownership through the bus arbiter. It then drives the result, and optionally the flags, back onto the bus. It sits between the microcode control unit (start/cmd handshake) and the ALU unit's operand registers, result register and bus arbiter.

Parameters:
TMO, 8, number of cycles to wait for bus_gnt (or operand valid) in a wait state before aborting; legal range 2..255
CW, 8, width of the internal timeout counter; must satisfy 2^CW > TMO

Ports:
clk  input  1  system clock, rising edge
grst  input  1  global reset, asynchronous, active-high
start  input  1  command strobe from control unit; sampled only in IDLE
cmd  input  3  ALU function; cmd[2]=1 means unary (single operand)
flg_rd  input  1  with start: also drive flags onto bus after result
clr  input  1  clear result/flag registers; sampled only in IDLE
opnd_vld  input  1  operand currently present on bus
bus_gnt  input  1  bus grant from arbiter
busy  output  1  high in every state except IDLE and DONE
done  output  1  one-cycle pulse at end of a command or clear
err  output  1  one-cycle pulse on timeout abort
ld_a  output  1  load operand A register from bus
ld_b  output  1  load operand B register from bus
alu_fn  output  3  latched cmd, stable while busy
op_sel  output  2  ALU execute enable: 01 binary, 10 unary, 00 otherwise
lrst  output  1  local reset to result register
bus_req  output  1  request to bus arbiter
ws1  output  1  result register drives bus
ws2  output  1  flag register drives bus

Behaviour:
- States: IDLE, CLR, LDA, LDB, EXEC, REQ, WRES, WFLG, DONE, ABORT; binary-encoded register.
- Reset: state=IDLE, timeout counter=0, alu_fn=000, flg latch=0; all outputs 0. grst mid-command aborts at once: no done, no err, no ws pulse afterwards.
- IDLE: clr has priority over start. clr -> CLR. Otherwise start -> LDA, latching cmd into alu_fn and flg_rd into the flg latch. start/clr outside IDLE are ignored, not queued.
- CLR: lrst=1 for exactly one cycle -> DONE.
- LDA: ld_a = opnd_vld (combinational). opnd_vld=1 -> LDB if alu_fn[2]=0, else EXEC.
- LDB: ld_b = opnd_vld. opnd_vld=1 -> EXEC.
- EXEC: one cycle; op_sel = 10 if alu_fn[2] else 01 -> REQ.
- REQ: bus_req=1; bus_gnt=1 -> WRES.
- WRES: bus_req=1; ws1 = bus_gnt. bus_gnt=1 -> WFLG if flg latch set, else DONE. bus_gnt=0 -> stay in WRES.
- WFLG: bus_req=1; ws2 = bus_gnt. bus_gnt=1 -> DONE.
- ws1 and ws2 are never both high. Neither is high without bus_gnt.
- DONE: done=1 for one cycle, busy=0 -> IDLE. A start in DONE is ignored.
- Timeout: counter clears on every state change. It increments each cycle in LDA, LDB, REQ, WRES or WFLG while the awaited input (opnd_vld or bus_gnt) is 0. When the count reaches TMO-1 with the input still 0 -> ABORT. An input arriving in the same cycle as expiry wins; the transition proceeds normally.
- ABORT: err=1 for one cycle, bus_req=0, no done -> IDLE. Result register contents are left unchanged.
- Best-case latency, with opnd_vld and bus_gnt already high:
  - binary without flags: start in cycle 0, done in cycle 6
  - unary: one cycle less
  - with flg_rd: one cycle more
- alu_fn holds its value after DONE until the next accepted start.

Test Plan:
- Reset: grst pulse mid-LDB -> next cycle state IDLE; all outputs 0; no done/err.
- Binary op: cmd=011, flg_rd=0, opnd_vld and bus_gnt held 1 -> ld_a in cycle 1, ld_b cycle 2, op_sel=01 cycle 3, bus_req cycles 4-5, ws1 cycle 5, done cycle 6, alu_fn=011 throughout.
- Unary op with flags: cmd=101, flg_rd=1 -> no ld_b; op_sel=10 cycle 2; ws1 cycle 4; ws2 cycle 5; done cycle 6.
- Grant delay and loss: bus_gnt low 3 cycles in REQ, then high, then dropped for 2 cycles in WRES -> ws1 only while gnt=1, exactly one ws1-high cycle; no err.
- Timeout: TMO=8, bus_gnt held 0 -> ABORT after 8 REQ cycles; err one cycle; bus_req falls; next start accepted normally.
- Clear/priority: clr=1 and start=1 together in IDLE -> lrst one cycle, done next cycle, command discarded. start while busy -> ignored, alu_fn unchanged.
